schmidl_cox_peak_detector: RTL and testbench

//  Consumes P(d) and the aligned sample stream y(d-L) from the autocorrelator, plus energy R(d).

---
 rtl/schmidl_cox_pkg.sv | 24 ++
 rtl/sc_metric_pipe.sv | 74 +++++++
 rtl/schmidl_cox_peak_detector.sv | 227 ++++++++++++++++++++++
 tb/tb_schmidl_cox_peak_detector.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared types and widths for the Schmidl-Cox peak detector.
//   state_t          : detector control states
//   METRIC_PIPE_LAT  : join-to-metric latency of sc_metric_pipe (cycles)
//   *_W              : datapath widths of samples, P/R and the timing metric
package schmidl_cox_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        WINDOW  = 2'd1,
        ALIGN   = 2'd2,
        FORWARD = 2'd3
    } state_t;

    localparam int METRIC_PIPE_LAT = 3;

    localparam int SAMPLE_W = 32;              // {I,Q} s16
    localparam int IQ_W     = 16;
    localparam int R_W      = 16;              // R(d) unsigned
    localparam int THR_W    = 16;              // Q0.16 threshold
    localparam int A_W      = 33;              // |P|^2
    localparam int B_W      = 32;              // R^2
    localparam int CMP_W    = A_W + THR_W;     // (A<<16) vs threshold*B

endpackage

// File: rtl/sc_metric_pipe.sv
// Three-stage timing-metric pipeline.
//   Stage 1 registers the joined P/R values, stage 2 forms A=|P|^2 and
//   B=R^2, stage 3 evaluates the strict crossing (A<<16) > threshold*B.
//   No backpressure: the caller only issues a join when the sample buffer
//   has room, so every valid entering here is guaranteed a FIFO slot.
// Ports:
//   clk, srst_i       clock, synchronous active-high flush of the valids
//   in_valid_i        join strobe (s, p and r accepted this cycle)
//   p_data_i          P(d) {I,Q} signed 16-bit each
//   r_data_i          R(d) unsigned
//   threshold_i       Q0.16 metric threshold
//   out_valid_o       metric for the join METRIC_PIPE_LAT cycles earlier
//   out_a_o           |P|^2 of that join
//   out_cross_o       crossing flag of that join
module sc_metric_pipe
    import schmidl_cox_pkg::*;
(
    input  logic                clk,
    input  logic                srst_i,
    input  logic                in_valid_i,
    input  logic [SAMPLE_W-1:0] p_data_i,
    input  logic [R_W-1:0]      r_data_i,
    input  logic [THR_W-1:0]    threshold_i,
    output logic                out_valid_o,
    output logic [A_W-1:0]      out_a_o,
    output logic                out_cross_o
);

    logic [METRIC_PIPE_LAT-1:0] vld_q;
    logic signed [IQ_W-1:0]     pi_q;
    logic signed [IQ_W-1:0]     pq_q;
    logic [R_W-1:0]             r_q;
    logic [A_W-1:0]             a2_q;
    logic [B_W-1:0]             b2_q;
    logic [A_W-1:0]             a3_q;
    logic                       cross_q;

    logic signed [2*IQ_W-1:0]   sq_i;
    logic signed [2*IQ_W-1:0]   sq_q;
    logic [CMP_W-1:0]           lhs;
    logic [CMP_W-1:0]           rhs;

    // Squares of s16 values are non-negative and fit in 31 bits, so
    // zero-extending into the 33-bit sum is exact.
    assign sq_i = (2*IQ_W)'(pi_q) * (2*IQ_W)'(pi_q);
    assign sq_q = (2*IQ_W)'(pq_q) * (2*IQ_W)'(pq_q);

    assign lhs = {a2_q, {THR_W{1'b0}}};
    assign rhs = CMP_W'(threshold_i) * CMP_W'(b2_q);

    always_ff @(posedge clk) begin
        if (srst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[METRIC_PIPE_LAT-2:0], in_valid_i};
        end
    end

    // Data stages carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        pi_q    <= p_data_i[SAMPLE_W-1:IQ_W];
        pq_q    <= p_data_i[IQ_W-1:0];
        r_q     <= r_data_i;
        a2_q    <= {1'b0, sq_i} + {1'b0, sq_q};
        b2_q    <= B_W'(r_q) * B_W'(r_q);
        a3_q    <= a2_q;
        cross_q <= (lhs > rhs);
    end

    assign out_valid_o = vld_q[METRIC_PIPE_LAT-1];
    assign out_a_o     = a3_q;
    assign out_cross_o = cross_q;

endmodule

// File: rtl/schmidl_cox_peak_detector.sv
// Schmidl-Cox plateau/peak detector and frame gate.
//   Joins sample s, correlation P and energy R, buffers samples while their
//   metric is computed, locates the |P|^2 peak inside a search window after
//   the first threshold crossing and forwards frame_len samples from the
//   peak sample as one packet.
// Ports:
//   clk, reset, clear       clock; synchronous active-high reset; clear flushes
//                           like reset but keeps detect_count
//   threshold/window_len/frame_len   configuration
//   s_*, p_*, r_*           joined input streams (tlast ignored)
//   o_*                     forwarded frame, o_tlast on the last sample
//   frame_start             one-cycle pulse when the peak is fixed
//   detect_count            detections since reset (wraps)
module schmidl_cox_peak_detector
    import schmidl_cox_pkg::*;
#(
    parameter int MAX_WINDOW = 128,
    parameter int FIFO_AW    = 9
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic [THR_W-1:0]                  threshold,
    input  logic [$clog2(MAX_WINDOW+1)-1:0]   window_len,
    input  logic [15:0]                       frame_len,
    input  logic [SAMPLE_W-1:0]               s_tdata,
    input  logic                              s_tlast,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic [SAMPLE_W-1:0]               p_tdata,
    input  logic                              p_tlast,
    input  logic                              p_tvalid,
    output logic                              p_tready,
    input  logic [R_W-1:0]                    r_tdata,
    input  logic                              r_tvalid,
    output logic                              r_tready,
    output logic [SAMPLE_W-1:0]               o_tdata,
    output logic                              o_tlast,
    output logic                              o_tvalid,
    input  logic                              o_tready,
    output logic                              frame_start,
    output logic [31:0]                       detect_count
);

    localparam int WL_W  = $clog2(MAX_WINDOW+1);
    localparam int DEPTH = 1 << FIFO_AW;

    logic flush;
    logic join_ok;
    logic unused_tlast;

    assign flush        = reset | clear;
    assign unused_tlast = s_tlast ^ p_tlast;

    // ---------------- sample buffer (first-word fall-through) -------------
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q;
    logic [FIFO_AW-1:0]  rd_ptr_q;
    logic [FIFO_AW:0]    count_q;
    logic                full;
    logic                empty;
    logic                pop;

    assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign join_ok  = s_tvalid & p_tvalid & r_tvalid & ~full & ~flush;
    assign s_tready = join_ok;
    assign p_tready = join_ok;
    assign r_tready = join_ok;

    always_ff @(posedge clk) begin
        if (join_ok) begin
            mem[wr_ptr_q] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (join_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (FIFO_AW+1)'(join_ok) - (FIFO_AW+1)'(pop);
        end
    end

    // Head stays put unless popped, which keeps o_tdata/o_tlast stable
    // while the consumer stalls.
    assign o_tdata = mem[rd_ptr_q];

    // ---------------- metric pipeline ------------------------------------
    logic           m_valid;
    logic [A_W-1:0] m_a;
    logic           m_cross;

    sc_metric_pipe u_metric (
        .clk         (clk),
        .srst_i      (flush),
        .in_valid_i  (join_ok),
        .p_data_i    (p_tdata),
        .r_data_i    (r_tdata),
        .threshold_i (threshold),
        .out_valid_o (m_valid),
        .out_a_o     (m_a),
        .out_cross_o (m_cross)
    );

    // ---------------- control --------------------------------------------
    // Samples and metrics are tracked by absolute index: m_q is the index
    // of the next metric to leave the pipe, h_q the index of the FIFO head.
    // Comparing them keeps metric/sample alignment across stalls and after
    // a frame, where the head may lead or lag the metric stream.
    state_t            state_q,    state_d;
    logic [A_W-1:0]    peak_q,     peak_d;
    logic [31:0]       peak_idx_q, peak_idx_d;
    logic [WL_W-1:0]   win_rem_q,  win_rem_d;
    logic [15:0]       fwd_rem_q,  fwd_rem_d;
    logic [31:0]       m_q;
    logic [31:0]       h_q;
    logic              frame_start_q;
    logic [31:0]       detect_count_q;
    logic              finish;

    logic signed [31:0] mh_diff;
    logic signed [31:0] ph_diff;

    assign mh_diff = m_q - h_q;
    assign ph_diff = peak_idx_q - h_q;

    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        win_rem_d  = win_rem_q;
        fwd_rem_d  = fwd_rem_q;
        pop        = 1'b0;
        finish     = 1'b0;
        o_tvalid   = 1'b0;
        o_tlast    = 1'b0;
        unique case (state_q)
            SEARCH: begin
                // Head already evaluated (non-crossing, or ignored while a
                // frame was out): discard it.
                if (mh_diff > 0 && !empty) pop = 1'b1;
                // Metrics of samples already forwarded (mh_diff < 0) cannot arm.
                if (m_valid && m_cross && mh_diff >= 0) begin
                    peak_d     = m_a;
                    peak_idx_d = m_q;
                    win_rem_d  = (window_len == '0) ? '0 : window_len - WL_W'(1);
                    state_d    = WINDOW;
                end
            end
            WINDOW: begin
                // Anything ahead of the current peak can never be the frame start.
                if (ph_diff > 0 && !empty) pop = 1'b1;
                if (win_rem_q == '0) begin
                    finish = 1'b1;
                end else if (m_valid) begin
                    if (m_a > peak_q) begin
                        peak_d     = m_a;
                        peak_idx_d = m_q;
                    end
                    win_rem_d = win_rem_q - WL_W'(1);
                    if (win_rem_q == WL_W'(1)) finish = 1'b1;
                end
                if (finish) begin
                    fwd_rem_d = (frame_len == 16'd0) ? 16'd1 : frame_len;
                    state_d   = ALIGN;
                end
            end
            ALIGN: begin
                if (ph_diff > 0) begin
                    pop = ~empty;
                end else begin
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                o_tvalid = ~empty;
                o_tlast  = ~empty && (fwd_rem_q == 16'd1);
                if (o_tvalid && o_tready) begin
                    pop       = 1'b1;
                    fwd_rem_d = fwd_rem_q - 16'd1;
                    if (fwd_rem_q == 16'd1) state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q       <= SEARCH;
            peak_q        <= '0;
            peak_idx_q    <= '0;
            win_rem_q     <= '0;
            fwd_rem_q     <= '0;
            m_q           <= '0;
            h_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            peak_q        <= peak_d;
            peak_idx_q    <= peak_idx_d;
            win_rem_q     <= win_rem_d;
            fwd_rem_q     <= fwd_rem_d;
            frame_start_q <= finish;
            if (m_valid) m_q <= m_q + 32'd1;
            if (pop)     h_q <= h_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            detect_count_q <= '0;
        end else if (!clear && finish) begin
            detect_count_q <= detect_count_q + 32'd1;
        end
    end

    assign frame_start  = frame_start_q;
    assign detect_count = detect_count_q;

endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// Directed bench for schmidl_cox_peak_detector. A reference model computes
// the expected output packets from the whole input record (metric, window
// search, frame extraction); a monitor compares every accepted output
// sample against it.
module tb_schmidl_cox_peak_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] threshold = 16'h8000;
    logic [7:0]  window_len = 8'd16;
    logic [15:0] frame_len = 16'd64;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] p_tdata = '0;
    logic        p_tlast = 1'b0;
    logic        p_tvalid = 1'b0;
    logic        p_tready;
    logic [15:0] r_tdata = '0;
    logic        r_tvalid = 1'b0;
    logic        r_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        frame_start;
    logic [31:0] detect_count;

    always #5 clk = ~clk;

    schmidl_cox_peak_detector #(.MAX_WINDOW(128), .FIFO_AW(9)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .threshold(threshold), .window_len(window_len), .frame_len(frame_len),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .p_tdata(p_tdata), .p_tlast(p_tlast), .p_tvalid(p_tvalid), .p_tready(p_tready),
        .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .frame_start(frame_start), .detect_count(detect_count)
    );

    // ---------------- bookkeeping ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- input record and model ----------------
    localparam int MAXN = 2048;
    int          pi_a [MAXN];
    int          pq_a [MAXN];
    int          r_a  [MAXN];
    logic [31:0] s_a  [MAXN];

    typedef struct {
        logic [31:0] d;
        bit          last;
    } out_t;
    out_t exp_q[$];

    function automatic logic [31:0] samp(input int n);
        logic [15:0] v;
        v = 16'(n);
        return {v, ~v};
    endfunction

    task automatic gen_base(input int n_len, input int r);
        for (int i = 0; i < n_len; i++) begin
            pi_a[i] = 0;
            pq_a[i] = 0;
            r_a[i]  = r;
            s_a[i]  = samp(i);
        end
    endtask

    // Triangular |P| ramp centred on c; with R=100 and threshold 0.5 the
    // metric first exceeds the threshold 5 samples before the centre.
    task automatic add_preamble(input int c);
        for (int d = -8; d <= 8; d++) begin
            pi_a[c+d] = 25 * (8 - ((d < 0) ? -d : d));
        end
    endtask

    function automatic longint metric_a(input int n);
        return longint'(pi_a[n]) * pi_a[n] + longint'(pq_a[n]) * pq_a[n];
    endfunction

    function automatic bit crosses(input int n, input int thr);
        longint b;
        b = longint'(r_a[n]) * r_a[n];
        return (metric_a(n) * 65536) > (longint'(thr) * b);
    endfunction

    task automatic build_expected(input int n_len, input int thr, input int wl,
                                  input int fl, output int dets);
        int n;
        n = 0;
        dets = 0;
        exp_q.delete();
        while (n < n_len) begin
            if (crosses(n, thr)) begin
                int pk;
                longint pa;
                int weff;
                int feff;
                pk = n;
                pa = metric_a(n);
                weff = (wl < 1) ? 1 : wl;
                feff = (fl < 1) ? 1 : fl;
                for (int k = 1; k < weff; k++) begin
                    if (metric_a(n + k) > pa) begin
                        pa = metric_a(n + k);
                        pk = n + k;
                    end
                end
                for (int j = 0; j < feff; j++) begin
                    out_t e;
                    e.d = s_a[pk + j];
                    e.last = (j == feff - 1);
                    exp_q.push_back(e);
                end
                dets++;
                n = pk + feff;
            end else begin
                n++;
            end
        end
    endtask

    // ---------------- output pacing ----------------
    bit rdy_random = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            o_tready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- compare process ----------------
    int fs_cnt = 0;
    int valid_cnt = 0;
    int stall_cnt = 0;
    int out_seen = 0;
    int pkt_len = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !clear) begin
                if (frame_start) fs_cnt++;
                if (o_tvalid) valid_cnt++;
                if (prev_stall) begin
                    check("hold_valid", o_tvalid, 1);
                    check("hold_data", o_tdata, prev_data);
                    check("hold_last", o_tlast, prev_last);
                end
                if (o_tvalid && !o_tready) stall_cnt++;
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        out_t e;
                        e = exp_q.pop_front();
                        check("out_data", o_tdata, e.d);
                        check("out_last", o_tlast, e.last);
                    end
                    out_seen++;
                    pkt_len++;
                    if (o_tlast) begin
                        $display("[TB] packet of %0d samples, last data %08h", pkt_len, o_tdata);
                        pkt_len = 0;
                    end
                end
                prev_stall = o_tvalid && !o_tready;
                prev_data  = o_tdata;
                prev_last  = o_tlast;
            end else begin
                prev_stall = 1'b0;
                pkt_len = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_tvalid = 1'b0;
        p_tvalid = 1'b0;
        r_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_detect_count", detect_count, 0);
        check("rst_s_tready", s_tready, 0);
        fs_cnt = 0;
        valid_cnt = 0;
        stall_cnt = 0;
        out_seen = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_stream(input int n_len, input int stop_after);
        for (int i = 0; i < n_len; i++) begin
            int tmo;
            bit ok;
            if (stop_after > 0 && out_seen >= stop_after) break;
            s_tdata  = s_a[i];
            p_tdata  = {16'(pi_a[i]), 16'(pq_a[i])};
            r_tdata  = 16'(r_a[i]);
            s_tvalid = 1'b1;
            p_tvalid = 1'b1;
            r_tvalid = 1'b1;
            tmo = 0;
            do begin
                #1;
                ok = s_tready && p_tready && r_tready;
                @(negedge clk);
                tmo++;
            end while (!ok && tmo < 2000);
            if (!ok) begin
                check("input_accept_timeout", 0, 1);
                break;
            end
        end
        s_tvalid = 1'b0;
        p_tvalid = 1'b0;
        r_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 5000) begin
            @(negedge clk);
            tmo++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic run_case(input int n_len, input int dets, input int nout);
        do_reset();
        drive_stream(n_len, 0);
        wait_drain();
        check("frame_start_pulses", fs_cnt, dets);
        check("detect_count", detect_count, dets);
        check("outputs_seen", out_seen, nout);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int dets;

        // 1: silence never crosses
        gen_base(300, 100);
        build_expected(300, 32'h8000, 16, 64, dets);
        check("t1_model_dets", dets, 0);
        run_case(300, 0, 0);
        check("t1_valid_cycles", valid_cnt, 0);

        // 2: single preamble, peak at 200
        gen_base(300, 100);
        add_preamble(200);
        check("t2_model_cross195", crosses(195, 32'h8000), 1);
        check("t2_model_cross194", crosses(194, 32'h8000), 0);
        build_expected(300, 32'h8000, 16, 64, dets);
        check("t2_model_dets", dets, 1);
        check("t2_model_len", exp_q.size(), 64);
        check("t2_model_first", exp_q[0].d, 32'h00C8FF37);
        check("t2_model_lastd", exp_q[63].d, 32'h0107FEF8);
        check("t2_model_lastf", exp_q[63].last, 1);
        run_case(300, 1, 64);

        // 3: equal maxima at 200 and 205, earliest wins
        gen_base(300, 100);
        add_preamble(200);
        pi_a[205] = 200;
        build_expected(300, 32'h8000, 16, 64, dets);
        check("t3_model_first", exp_q[0].d, 32'h00C8FF37);
        run_case(300, 1, 64);

        // 4: as case 2 with random output backpressure
        gen_base(300, 100);
        add_preamble(200);
        build_expected(300, 32'h8000, 16, 64, dets);
        rdy_random = 1'b1;
        run_case(300, 1, 64);
        check("t4_stalls_seen", (stall_cnt > 0) ? 1 : 0, 1);
        rdy_random = 1'b0;

        // 5: reset in the middle of a frame, then a clean redetection
        gen_base(300, 100);
        add_preamble(200);
        build_expected(300, 32'h8000, 16, 64, dets);
        do_reset();
        drive_stream(300, 10);
        reset = 1'b1;
        s_tvalid = 1'b0;
        p_tvalid = 1'b0;
        r_tvalid = 1'b0;
        @(negedge clk);
        #2;
        check("t5_valid_after_reset", o_tvalid, 0);
        check("t5_truncated", (out_seen >= 10 && out_seen < 64) ? 1 : 0, 1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        build_expected(300, 32'h8000, 16, 64, dets);
        run_case(300, 1, 64);

        // 6: two preambles 1000 apart, a third one inside the first frame
        gen_base(1600, 100);
        add_preamble(200);
        add_preamble(350);
        add_preamble(1200);
        build_expected(1600, 32'h8000, 16, 300, dets);
        check("t6_model_dets", dets, 2);
        check("t6_model_len", exp_q.size(), 600);
        check("t6_model_second", exp_q[300].d, 32'h04B0FB4F);
        frame_len = 16'd300;
        run_case(1600, 2, 600);

        // clear flushes but keeps the detection count
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        #3;
        check("clear_keeps_count", detect_count, 2);
        check("clear_o_tvalid", o_tvalid, 0);
        clear = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
